// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding load/store initiator for the data_memory
//                port. Decodes RV32 funct3 into byte masks and lane-replicated
//                store data, sign/zero-extends load data, waits out partial
//                store read-modify-write cycles, and rejects misaligned or
//                illegal accesses without touching memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  // core request side
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [2:0]         req_funct3_i,
  input  logic [width_p-1:0] req_addr_i,
  input  logic [width_p-1:0] req_wdata_i,
  // core response side
  output logic               rsp_valid_o,
  output logic [width_p-1:0] rsp_rdata_o,
  output logic               rsp_error_o,
  // memory side
  output logic [width_p-1:0] mem_addr_o,
  output logic               mem_read_enable_o,
  output logic               mem_write_enable_o,
  output logic [width_p-1:0] mem_write_data_o,
  output logic [3:0]         mem_write_mask_o,
  input  logic [width_p-1:0] mem_read_data_i,
  input  logic               mem_busy_i
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    LOAD_DATA  = 3'd2,
    STORE_WAIT = 3'd3,
    RESP       = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_we;
  logic [2:0]         r_funct3;
  logic [width_p-1:0] r_addr;
  logic [3:0]         r_wmask;
  logic [width_p-1:0] r_wdata;
  logic [width_p-1:0] r_rsp_rdata;
  logic               r_rsp_error;

  logic               w_legal;
  logic               w_misaligned;
  logic               w_req_error;
  logic [3:0]         w_store_mask;
  logic [width_p-1:0] w_store_data;
  logic [7:0]         w_load_byte;
  logic [15:0]        w_load_half;
  logic [width_p-1:0] w_load_data;

  // Classify the incoming request: legal funct3 for its direction and natural alignment.
  always_comb begin
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~req_we_i;   // unsigned variants exist for loads only
      default:                w_legal = 1'b0;
    endcase
    case (req_funct3_i[1:0])
      2'b01:   w_misaligned = req_addr_i[0];
      2'b10:   w_misaligned = (req_addr_i[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
    w_req_error = ~w_legal | w_misaligned;
  end

  // Build the byte-enable mask and lane-replicated data for a store request.
  always_comb begin
    w_store_mask = 4'b1111;
    w_store_data = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        w_store_mask = 4'b0001 << req_addr_i[1:0];
        w_store_data = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_store_mask = req_addr_i[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{req_wdata_i[15:0]}};
      end
      default: begin
        w_store_mask = 4'b1111;
        w_store_data = req_wdata_i;
      end
    endcase
  end

  // Select the addressed lane of the returned word and extend it to full width.
  always_comb begin
    w_load_byte = mem_read_data_i[{r_addr[1:0], 3'b000} +: 8];
    w_load_half = r_addr[1] ? mem_read_data_i[31:16] : mem_read_data_i[15:0];
    w_load_data = mem_read_data_i;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_load_byte[7]}}, w_load_byte};
      3'b001:  w_load_data = {{16{w_load_half[15]}}, w_load_half};
      3'b100:  w_load_data = {24'd0, w_load_byte};
      3'b101:  w_load_data = {16'd0, w_load_half};
      default: w_load_data = mem_read_data_i;
    endcase
  end

  // Advance the transaction state; reset abandons any operation in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and the strobes/handshakes that depend only on state.
  always_comb begin
    w_state_next       = r_state;
    req_ready_o        = 1'b0;
    mem_read_enable_o  = 1'b0;
    mem_write_enable_o = 1'b0;
    rsp_valid_o        = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = reset_ni;
        if (req_valid_i) begin
          w_state_next = w_req_error ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_read_enable_o  = ~r_we;
        mem_write_enable_o = r_we;
        if (!r_we) begin
          w_state_next = LOAD_DATA;
        end else if (mem_busy_i) begin
          w_state_next = STORE_WAIT;
        end else begin
          w_state_next = RESP;
        end
      end
      LOAD_DATA: begin
        w_state_next = RESP;
      end
      STORE_WAIT: begin
        if (!mem_busy_i) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid_o  = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Capture the request on acceptance and update response data as it becomes final.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= '0;
      r_wmask     <= 4'd0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_we     <= req_we_i;
            r_funct3 <= req_funct3_i;
            r_addr   <= req_addr_i;
            // Mask stays zero for loads and rejected requests so no lane is ever enabled.
            r_wmask  <= (req_we_i && !w_req_error) ? w_store_mask : 4'd0;
            r_wdata  <= (req_we_i && !w_req_error) ? w_store_data : '0;
            if (w_req_error) begin
              r_rsp_rdata <= '0;
              r_rsp_error <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (r_we && !mem_busy_i) begin
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
          end
        end
        LOAD_DATA: begin
          r_rsp_rdata <= w_load_data;
          r_rsp_error <= 1'b0;
        end
        STORE_WAIT: begin
          if (!mem_busy_i) begin
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr_o       = r_addr;
  assign mem_write_mask_o = r_wmask;
  assign mem_write_data_o = r_wdata;
  assign rsp_rdata_o      = r_rsp_rdata;
  assign rsp_error_o      = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit with a small
//                byte-masked memory model that raises busy for partial writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, mem_busy;
  logic [3:0]  mem_mask;

  always #5 clk = ~clk;

  load_store_unit #(.width_p(32)) dut (
    .clk_i              (clk),
    .reset_ni           (reset_n),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_we_i           (req_we),
    .req_funct3_i       (req_funct3),
    .req_addr_i         (req_addr),
    .req_wdata_i        (req_wdata),
    .rsp_valid_o        (rsp_valid),
    .rsp_rdata_o        (rsp_rdata),
    .rsp_error_o        (rsp_error),
    .mem_addr_o         (mem_addr),
    .mem_read_enable_o  (mem_re),
    .mem_write_enable_o (mem_we),
    .mem_write_data_o   (mem_wdata),
    .mem_write_mask_o   (mem_mask),
    .mem_read_data_i    (mem_rdata),
    .mem_busy_i         (mem_busy)
  );

  // Memory model: 16 words, read data one cycle after strobe, partial writes busy for two cycles.
  logic [31:0] mem [16];
  logic        preload;
  logic [1:0]  busy_cnt;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h8877_6655;
      mem[8] <= 32'h1122_3344;
      mem[9] <= 32'h0000_007F;
    end
    if (!reset_n) begin
      busy_cnt  <= 2'd0;
      mem_rdata <= 32'd0;
    end else begin
      if (mem_re) mem_rdata <= mem[mem_addr[5:2]];
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        busy_cnt <= (mem_mask != 4'hF) ? 2'd1 : 2'd0;
      end else if (busy_cnt != 2'd0) begin
        busy_cnt <= busy_cnt - 2'd1;
      end
    end
  end

  assign mem_busy = (mem_we && (mem_mask != 4'hF)) || (busy_cnt != 2'd0);

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[20];
  vec_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_lat,
                              input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_mask = exp_mask; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {22'd0, rsp_valid, rsp_error, mem_re, mem_we, req_ready, 1'b0, mem_mask}, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
  endtask

  // Drive one request, hold garbage on valid for a cycle after acceptance, then score the response.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int   rd_n, wr_n, lat;
    bit   got;
    sb.push_back(v);
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_funct3 = 3'b011; req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
    rd_n = 0; wr_n = 0; lat = 0; got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (c == 2) req_valid = 1'b0;
      if (mem_re || mem_we) begin
        chk("strobe_cycle", c, 1);
        chk("strobe_addr", mem_addr, v.addr);
      end
      if (mem_re) rd_n++;
      if (mem_we) begin
        wr_n++;
        chk("store_mask", {28'd0, mem_mask}, {28'd0, v.exp_mask});
        chk("store_data", mem_wdata, v.exp_wdata);
      end
      if (rsp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    req_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rsp_timeout: got no response, expected one at cycle %0d", v.exp_lat);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk("latency", lat, e.exp_lat);
      chk("rsp_rdata", rsp_rdata, e.exp_rdata);
      chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.exp_err});
      chk("read_strobes", rd_n, (!e.exp_err && !e.we) ? 1 : 0);
      chk("write_strobes", wr_n, (!e.exp_err && e.we) ? 1 : 0);
      @(negedge clk);
      chk("rsp_pulse_end", {30'd0, rsp_valid, req_ready}, 32'd1);
      chk("rsp_rdata_hold", rsp_rdata, e.exp_rdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 3'b010, 32'h10, 0, 32'h8877_6655, 0, 3, 0, 0);
    vecs[1]  = mk(0, 3'b000, 32'h13, 0, 32'hFFFF_FF88, 0, 3, 0, 0);
    vecs[2]  = mk(0, 3'b100, 32'h13, 0, 32'h0000_0088, 0, 3, 0, 0);
    vecs[3]  = mk(0, 3'b001, 32'h12, 0, 32'hFFFF_8877, 0, 3, 0, 0);
    vecs[4]  = mk(0, 3'b101, 32'h10, 0, 32'h0000_6655, 0, 3, 0, 0);
    vecs[5]  = mk(1, 3'b000, 32'h21, 32'h1234_56AB, 0, 0, 4, 4'b0010, 32'hABAB_ABAB);
    vecs[6]  = mk(0, 3'b010, 32'h20, 0, 32'h1122_AB44, 0, 3, 0, 0);
    vecs[7]  = mk(1, 3'b010, 32'h20, 32'hDEAD_BEEF, 0, 0, 2, 4'b1111, 32'hDEAD_BEEF);
    vecs[8]  = mk(1, 3'b001, 32'h03, 32'h0000_FFFF, 0, 1, 1, 0, 0);
    vecs[9]  = mk(0, 3'b010, 32'h02, 0, 0, 1, 1, 0, 0);
    vecs[10] = mk(0, 3'b011, 32'h10, 0, 0, 1, 1, 0, 0);
    vecs[11] = mk(1, 3'b100, 32'h20, 32'h0, 0, 1, 1, 0, 0);
    vecs[12] = mk(0, 3'b010, 32'h20, 0, 32'hDEAD_BEEF, 0, 3, 0, 0);
    vecs[13] = mk(1, 3'b001, 32'h26, 32'h5555_CAFE, 0, 0, 4, 4'b1100, 32'hCAFE_CAFE);
    vecs[14] = mk(0, 3'b001, 32'h26, 0, 32'hFFFF_CAFE, 0, 3, 0, 0);
    vecs[15] = mk(0, 3'b101, 32'h26, 0, 32'h0000_CAFE, 0, 3, 0, 0);
    vecs[16] = mk(0, 3'b000, 32'h24, 0, 32'h0000_007F, 0, 3, 0, 0);
    vecs[17] = mk(0, 3'b100, 32'h27, 0, 32'h0000_00CA, 0, 3, 0, 0);
    vecs[18] = mk(0, 3'b101, 32'h13, 0, 0, 1, 1, 0, 0);
    vecs[19] = mk(0, 3'b110, 32'h10, 0, 0, 1, 1, 0, 0);

    reset_n = 1'b0; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while a partial store sits in STORE_WAIT: no response, outputs cleared.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h25; req_wdata = 32'h11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_strobe", {31'd0, mem_we}, 32'd1);
    @(negedge clk);
    chk("pre_rst_busy", {30'd0, mem_busy, rsp_valid}, 32'd2);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
    run_vec(mk(0, 3'b010, 32'h10, 0, 32'h8877_6655, 0, 3, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the `data_memory` port: accepts one load or store at a time from the core's memory stage and converts RV32 funct3 semantics (LB/LH/LW/LBU/LHU, SB/SH/SW) into memory strobes. On the memory side it drives byte-addressed accesses, 4-bit write masks and lane-replicated write data, and honours `busy_o` for partial-word read-modify-write stores. It extracts and sign/zero-extends load data, rejects misaligned or illegal accesses without touching memory, and returns one response pulse per request.

## Interface
- `width_p`, 32, data/address width; only 32 is supported.
- `clk_i`  in  1  clock.
- `reset_ni`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  1  core request valid.
- `req_ready_o`  out  1  unit can accept a request.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_funct3_i`  in  3  RV32 load/store funct3.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data, right-aligned.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_rdata_o`  out  32  extended load data; 0 for stores and errors.
- `rsp_error_o`  out  1  misaligned or illegal funct3; valid with `rsp_valid_o`.
- `mem_addr_o`  out  32  byte address to memory.
- `mem_read_enable_o`  out  1  load strobe.
- `mem_write_enable_o`  out  1  store strobe.
- `mem_write_data_o`  out  32  lane-replicated store data.
- `mem_write_mask_o`  out  4  byte-enable mask.
- `mem_read_data_i`  in  32  memory read data, valid one cycle after the read strobe.
- `mem_busy_i`  in  1  memory busy (read-modify-write in progress).

## Operation
- FSM states: IDLE, ISSUE, LOAD_DATA, STORE_WAIT, RESP.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i`, register `we`, `funct3`, `addr` and `wdata`.
  - Legal access -> ISSUE. Error -> RESP with `rsp_error_o`=1; no memory strobe.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal.
- Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
- ISSUE: exactly one cycle of `mem_read_enable_o` or `mem_write_enable_o`.
  - Load -> LOAD_DATA.
  - Store with `mem_busy_i`=0 -> RESP.
  - Store with `mem_busy_i`=1 -> STORE_WAIT.
- LOAD_DATA: register the extracted `mem_read_data_i` into `rsp_rdata_o`; -> RESP.
- STORE_WAIT: strobes low. Stay while `mem_busy_i`=1; -> RESP on the first cycle `mem_busy_i`=0.
- RESP: `rsp_valid_o`=1 for one cycle; -> IDLE.
- Store mask and data:
  - SB: mask = 0001 << `addr[1:0]`; data = byte replicated ×4.
  - SH: mask = 0011 << (2·`addr[1]`); data = half replicated ×2.
  - SW: mask = 1111; data = `wdata`.
- Load extraction:
  - Byte = `rdata[8·addr[1:0] +: 8]`.
  - Half = `addr[1]` ? `rdata[31:16]` : `rdata[15:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `mem_addr_o` holds the registered address from ISSUE through RESP. Mask and write data are registered, and stable whenever `mem_write_enable_o`=1.
- `rsp_rdata_o` and `rsp_error_o` hold their values until the next response.
- `req_valid_i` outside IDLE is ignored (no acceptance).

## Timing
- Request accepted at cycle T (IDLE, valid & ready).
- Response `rsp_valid_o` timing:
  - Error: T+1.
  - Full-word store: T+2.
  - Load: T+3.
  - Partial store: T+4 (memory busy at T+1 and T+2, low at T+3).
- Next request is accepted no earlier than the cycle after RESP. This guarantees the memory has left its write state before the next strobe.
- Reset (`reset_ni`=0 at a clock edge):
  - State returns to IDLE.
  - `rsp_valid_o`, `rsp_error_o`, `rsp_rdata_o`, `mem_*_enable_o`, `mem_write_mask_o`, `mem_write_data_o` and `mem_addr_o` are cleared to 0.
  - `req_ready_o` is forced to 0 while `reset_ni`=0.
- Reset mid-transaction: the operation is abandoned and no response is issued. Store completion is not guaranteed; memory is reset from the same system reset.

## Test plan
- LW at `0x10`, memory word `0x8877_6655` -> read strobe at T+1 with `mem_addr_o`=`0x10`; `rsp_rdata_o`=`0x8877_6655` and `rsp_valid_o` at T+3.
- LB at `0x13` and LBU at `0x13` on word `0x8877_6655` -> `0xFFFF_FF88` and `0x0000_0088`. LH at `0x12` -> `0xFFFF_8877`; LHU at `0x10` -> `0x0000_6655`.
- SW `0xDEAD_BEEF` at `0x20` -> mask 1111, no busy, response at T+2; a readback LW returns `0xDEAD_BEEF`.
- SB `0xAB` at `0x21` over `0x1122_3344` -> mask 0010, data `0xABAB_ABAB`. Busy holds STORE_WAIT two cycles; response at T+4; readback `0x1122_AB44`.
- SH at `0x03`, LW at `0x02`, and funct3=011 -> each gives `rsp_error_o`=1 at T+1 with no memory strobe.
- Reset asserted while in STORE_WAIT -> next cycle IDLE, no `rsp_valid_o`, all outputs 0. A new LW after release completes normally.
